bit_set_gen: RTL and testbench
==============================

BIT_SET_GEN -- requirements
Module: bit_set_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the output word width; legal range is 2..64.
REQ-002 The module SHALL have localparam CW = $clog2(WIDTH+1), the count width.
REQ-003 The module SHALL have port clk, input, 1 bit: clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port go, input, 1 bit: start request, level-sampled on the rising edge.
REQ-006 The module SHALL have port in, input, CW bits: the requested number of asserted bits, unsigned.
REQ-007 The module SHALL have port out, output, WIDTH bits: the registered result word.
REQ-008 The module SHALL have port done, output, 1 bit: result valid; it SHALL stay high until the next accepted go.

Function
REQ-009 The block SHALL produce a WIDTH-bit word whose lowest k bits are 1 and all other bits are 0, where k = min(in, WIDTH).
- This is the inverse of the team's bit-count datapath: popcount(out) == k.
REQ-010 The FSM SHALL have exactly three states: START (the reset state), COMPUTE and RESTART.
REQ-011 In START, if go=1 at an edge, the block SHALL load n_r <= min(in, WIDTH), clear acc_r <= 0, and move to COMPUTE.
- If go=0, the state SHALL hold.
REQ-012 In RESTART, if go=1 at an edge, the block SHALL perform the same load as START, clear done, and move to COMPUTE.
- If go=0, the state and done=1 SHALL hold.
REQ-013 In COMPUTE, when n_r != 0, the block SHALL update acc_r <= {acc_r[WIDTH-2:0], 1'b1} and n_r <= n_r - 1 each cycle.
REQ-014 In COMPUTE, when n_r == 0, the block SHALL update out <= acc_r and done <= 1, and move to RESTART.
REQ-015 The in port SHALL be sampled only at the go-accept edge.
- Changes to in during COMPUTE or RESTART SHALL have no effect on the operation in progress.
REQ-016 The go input SHALL be ignored while in COMPUTE.
- Holding go high through COMPUTE SHALL neither restart nor extend the operation.
REQ-017 Latency: if go is accepted at edge t with k = min(in, WIDTH), done and the new out SHALL become visible after edge t+k+1.
- No other edge in that window SHALL change out or done.
REQ-018 The out register SHALL change only at the REQ-014 edge and SHALL otherwise hold its previous result, including throughout COMPUTE.
REQ-019 The done output SHALL fall at the edge that accepts go in RESTART and SHALL stay 0 until the next REQ-014 edge.
REQ-020 Saturation: in > WIDTH SHALL behave exactly as in = WIDTH: out = all ones, with latency WIDTH+1.
REQ-021 Zero case: in = 0 SHALL give out = 0 with latency 1, with done high after edge t+1.
REQ-022 Go held high continuously SHALL give back-to-back operations.
- Each RESTART lasts exactly one cycle, with done high for exactly that one cycle before being cleared.
REQ-023 The n_r register SHALL be CW bits wide and acc_r SHALL be WIDTH bits wide.
- The decrement SHALL never be performed at n_r == 0, so no wrap-around occurs.

Reset
REQ-024 While rst=1, the block SHALL force state = START, out = 0, done = 0, n_r = 0 and acc_r = 0, regardless of clk.
REQ-025 An assertion of rst during COMPUTE or RESTART SHALL abort the operation with no partial result on out.
- After release, the block SHALL wait in START for go.
REQ-026 The first rising edge after rst deasserts SHALL be able to accept go.

Verification (WIDTH=8, CW=4)
REQ-027 The bench SHALL drive reset, then go=1 for one cycle with in=3; it SHALL check that out=0x07 and done=1 after the 4th edge following accept, with out=0x00 and done=0 before that.
REQ-028 The bench SHALL run in=0 and check out=0x00 with done=1 after 1 edge; it SHALL then run in=8 and check out=0xFF with done=1 after 9 edges, with done dropping at the second go-accept edge.
REQ-029 The bench SHALL run in=13 (saturation) and check out=0xFF with latency 9 and popcount(out)=8.
REQ-030 The bench SHALL accept go with in=5, then change in to 2 and hold go=1 during COMPUTE.
- Result: out=0x1F at latency 6, then immediate restart loading in=2, with done high for one cycle.
REQ-031 The bench SHALL assert rst for 1 cycle at the 3rd edge of an in=7 operation whose previous result was 0x03.
- Response: out=0x00 and done=0 immediately.
- Response: no done until a new go; a new go with in=1 gives out=0x01 at latency 2.
REQ-032 The bench SHALL run a random sweep of in over 0..15 with random go gaps.
- Check for each run: out == (1<<min(in,8))-1, latency min(in,8)+1, and that out is stable whenever done=0.

Source files
------------

// File: rtl/bit_set_gen.sv
// bit_set_gen: produces a WIDTH-bit word whose lowest min(in, WIDTH) bits
// are set. The ones are shifted in one per cycle, and the result is
// registered on out together with a sticky done flag.
module bit_set_gen #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic [$clog2(WIDTH+1)-1:0]   in,
  output logic [WIDTH-1:0]             out,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    START   = 2'd0,
    COMPUTE = 2'd1,
    RESTART = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    n_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q;
  logic [CW-1:0]    k_sat;

  // Requests above WIDTH saturate to WIDTH ones.
  always_comb begin
    k_sat = (in > CW'(WIDTH)) ? CW'(WIDTH) : in;
  end

  // Control FSM with the datapath registers and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      n_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          if (go) begin
            n_q     <= k_sat;
            acc_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (n_q != '0) begin
            acc_q <= {acc_q[WIDTH-2:0], 1'b1};
            n_q   <= n_q - CW'(1);
          end else begin
            out_q   <= acc_q;
            done_q  <= 1'b1;
            state_q <= RESTART;
          end
        end
        RESTART: begin
          if (go) begin
            n_q     <= k_sat;
            acc_q   <= '0;
            done_q  <= 1'b0;
            state_q <= COMPUTE;
          end
        end
        default: begin
          state_q <= START;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_bit_set_gen.sv
// Self-checking bench for bit_set_gen at WIDTH=8. Expected results are
// pushed to a scoreboard when go is driven and popped when done rises.
module tb_bit_set_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic             go;
  logic [CW-1:0]    in;
  logic [WIDTH-1:0] out;
  logic             done;

  int unsigned tests_run;
  int unsigned tests_failed;

  typedef struct {
    logic [WIDTH-1:0] o;
    int unsigned      lat;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] prev_out;
  logic             exp_done;

  bit_set_gen #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .in   (in),
    .out  (out),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a go request now and record the expected result and latency.
  task automatic drive_go(input logic [CW-1:0] v);
    exp_t        e;
    int unsigned k;
    logic [WIDTH:0] t;
    k     = (v > WIDTH) ? WIDTH : int'(v);
    t     = ({{WIDTH{1'b0}}, 1'b1} << k) - 1;
    e.o   = t[WIDTH-1:0];
    e.lat = k + 1;
    sb.push_back(e);
    go = 1'b1;
    in = v;
  endtask

  // Starting just before the accept edge: check done drops, then wait for
  // done, checking out stability meanwhile, and compare with the scoreboard.
  task automatic wait_result(input bit hold, input logic [CW-1:0] new_in);
    int unsigned lat;
    bit          seen;
    exp_t        e;
    seen = 1'b0;
    lat  = 0;
    @(posedge clk); #1;
    check_val("done_low_at_accept", done, 0);
    check_val("out_hold_at_accept", out, prev_out);
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (hold) in = new_in;
      else      go = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      check_val("out_hold_busy", out, prev_out);
    end
    if (!seen) check_val("timeout_done", done, 1);
    if (sb.size() == 0) begin
      check_val("sb_empty", done, 0);
    end else begin
      e = sb.pop_front();
      check_val("result", out, e.o);
      check_val("latency", lat, e.lat);
    end
    prev_out = out;
    exp_done = done;
  endtask

  task automatic op(input logic [CW-1:0] v);
    @(negedge clk);
    drive_go(v);
    wait_result(1'b0, '0);
  endtask

  // Idle cycles with go low: out and done must hold.
  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      go = 1'b0;
      @(posedge clk); #1;
      check_val("idle_done", done, exp_done);
      check_val("idle_out", out, prev_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    prev_out     = '0;
    exp_done     = 1'b0;
    rst = 1'b1;
    go  = 1'b0;
    in  = '0;
    #1;
    check_val("reset_out_async", out, 0);
    check_val("reset_done_async", done, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_out", out, 0);
    check_val("reset_done", done, 0);

    // Go presented on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    drive_go(4'd3);
    wait_result(1'b0, '0);
    idle(2);

    op(4'd0);
    op(4'd8);
    idle(1);
    op(4'd13);
    check_val("popcount_sat", $countones(out), WIDTH);

    // in changed and go held during COMPUTE; back-to-back restart.
    @(negedge clk);
    drive_go(4'd5);
    wait_result(1'b1, 4'd2);
    drive_go(4'd2);
    wait_result(1'b0, '0);

    // Reset in the middle of an operation.
    op(4'd2);
    @(negedge clk);
    drive_go(4'd7);
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_out", out, 0);
    check_val("abort_done", done, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    prev_out = '0;
    exp_done = 1'b0;
    idle(3);
    op(4'd1);

    // Random sweep with random gaps.
    for (int unsigned r = 0; r < 24; r++) begin
      idle($urandom_range(0, 3));
      op(CW'($urandom_range(0, 15)));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
